// File: rtl/laser_chaser_pkg.sv
// ---------------------------------------------------------------------------
// laser_chaser_pkg
// Shared camera geometry defaults and the frame recovery FSM state encoding.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package laser_chaser_pkg;

  // Default camera geometry (QVGA, RGB565)
  localparam int CAM_H_PIXELS = 320;
  localparam int CAM_V_PIXELS = 240;
  localparam int CAM_PIXEL_W  = 16;

  // Frame recovery states: waiting for a frame boundary, inside a frame,
  // and past the last legal pixel of a frame.
  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACTIVE  = 2'd1,
    OVERRUN = 2'd2
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/rising_edge_detect.sv
// ---------------------------------------------------------------------------
// rising_edge_detect
// Produces a one-cycle pulse in the cycle where level_in goes from low to high.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rising_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic level_in,
  output logic pulse_out
);

  logic level_prev;

  // Remember last cycle's level so a held-high strobe only fires once
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level_in;
    end
  end

  assign pulse_out = level_in & ~level_prev;

endmodule

`default_nettype wire

// File: rtl/frame_recover.sv
// ---------------------------------------------------------------------------
// frame_recover
// Recovers raster position from a camera pixel strobe and end-of-frame
// marker. Frames are only trusted after the first frame_done_in; short and
// overlong frames are flagged on frame_error_out.
// Optional: define FRAME_RECOVER_STATS_EN to add per-frame statistics ports.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module frame_recover
  import laser_chaser_pkg::*;
#(
  parameter int H_PIXELS = CAM_H_PIXELS,
  parameter int V_PIXELS = CAM_V_PIXELS,
  parameter int PIXEL_W  = CAM_PIXEL_W,
  parameter int MIRROR_H = 0,
  localparam int HCOUNT_W = $clog2(H_PIXELS),
  localparam int VCOUNT_W = $clog2(V_PIXELS)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                valid_pixel_in,
  input  logic [PIXEL_W-1:0]  pixel_in,
  input  logic                frame_done_in,
  output logic [PIXEL_W-1:0]  pixel_out,
  output logic                data_valid_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                frame_start_out,
  output logic                frame_done_out,
  output logic                frame_error_out
`ifdef FRAME_RECOVER_STATS_EN
  ,
  output logic [15:0]         frame_count_out,
  output logic [19:0]         last_pixel_count_out
`endif
);

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_PIXELS - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_PIXELS - 1);

  frame_state_t        state;
  logic [HCOUNT_W-1:0] hcount;       // column of the next pixel to accept
  logic [VCOUNT_W-1:0] vcount;       // line of the next pixel to accept
  logic                overrun_err;  // pixels arrived after the last legal one
  logic                strobe_edge;

  rising_edge_detect u_strobe_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .level_in  (valid_pixel_in),
    .pulse_out (strobe_edge)
  );

  // Frame FSM: raster counting, pixel output register and frame pulses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= SYNC;
      hcount          <= '0;
      vcount          <= '0;
      overrun_err     <= 1'b0;
      pixel_out       <= '0;
      data_valid_out  <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      data_valid_out  <= 1'b0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      case (state)
        SYNC: begin
          // First frame boundary seen: the next pixel is (0,0)
          if (frame_done_in) begin
            state       <= ACTIVE;
            hcount      <= '0;
            vcount      <= '0;
            overrun_err <= 1'b0;
          end
        end
        ACTIVE, OVERRUN: begin
          if (frame_done_in) begin
            // End of frame wins over a coincident strobe edge
            frame_done_out  <= 1'b1;
            // Still ACTIVE means the frame never reached its last pixel
            frame_error_out <= (state == ACTIVE) | overrun_err;
            state           <= ACTIVE;
            hcount          <= '0;
            vcount          <= '0;
            overrun_err     <= 1'b0;
          end else if (strobe_edge) begin
            if (state == OVERRUN) begin
              overrun_err <= 1'b1;
            end else begin
              pixel_out       <= pixel_in;
              data_valid_out  <= 1'b1;
              hcount_out      <= (MIRROR_H != 0) ? (H_LAST - hcount) : hcount;
              vcount_out      <= vcount;
              frame_start_out <= (hcount == '0) && (vcount == '0);
              if (hcount == H_LAST) begin
                hcount <= '0;
                if (vcount == V_LAST) begin
                  vcount <= '0;
                  state  <= OVERRUN;
                end else begin
                  vcount <= vcount + 1'b1;
                end
              end else begin
                hcount <= hcount + 1'b1;
              end
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifdef FRAME_RECOVER_STATS_EN
  logic [19:0] pixel_count;  // pixels received this frame, overrun included

  // Per-frame statistics, latched alongside frame_done_out
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_count          <= '0;
      frame_count_out      <= '0;
      last_pixel_count_out <= '0;
    end else if (frame_done_in) begin
      pixel_count <= '0;
      if (state != SYNC) begin
        frame_count_out      <= frame_count_out + 16'd1;
        last_pixel_count_out <= pixel_count;
      end
    end else if (strobe_edge && (state != SYNC) && (pixel_count != 20'hFFFFF)) begin
      pixel_count <= pixel_count + 20'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_recover.sv
// ---------------------------------------------------------------------------
// tb_frame_recover
// Scoreboard bench for frame_recover. Two instances share one stimulus
// stream: a normal one and a horizontally mirrored one, both with a 4x2
// geometry so that full frames, overruns and boundaries stay short.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_recover;
  import laser_chaser_pkg::*;

  localparam int H = 4;
  localparam int V = 2;
  localparam int PW = 16;
  localparam int M_SYNC = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_OVERRUN = 2;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic valid_pixel_in = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic frame_done_in = 1'b0;

  logic [PW-1:0] pixel_out, m_pixel_out;
  logic data_valid_out, m_data_valid_out;
  logic [1:0] hcount_out, m_hcount_out;
  logic vcount_out, m_vcount_out;
  logic frame_start_out, m_frame_start_out;
  logic frame_done_out, m_frame_done_out;
  logic frame_error_out, m_frame_error_out;
`ifdef FRAME_RECOVER_STATS_EN
  logic [15:0] frame_count_out, m_frame_count_out;
  logic [19:0] last_pixel_count_out, m_last_pixel_count_out;
`endif

  frame_recover #(.H_PIXELS(H), .V_PIXELS(V), .PIXEL_W(PW), .MIRROR_H(0)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_pixel_in(valid_pixel_in), .pixel_in(pixel_in),
    .frame_done_in(frame_done_in), .pixel_out(pixel_out), .data_valid_out(data_valid_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .frame_start_out(frame_start_out),
    .frame_done_out(frame_done_out), .frame_error_out(frame_error_out)
`ifdef FRAME_RECOVER_STATS_EN
    , .frame_count_out(frame_count_out), .last_pixel_count_out(last_pixel_count_out)
`endif
  );

  frame_recover #(.H_PIXELS(H), .V_PIXELS(V), .PIXEL_W(PW), .MIRROR_H(1)) dut_m (
    .clk_in(clk), .rst_in(rst_in), .valid_pixel_in(valid_pixel_in), .pixel_in(pixel_in),
    .frame_done_in(frame_done_in), .pixel_out(m_pixel_out), .data_valid_out(m_data_valid_out),
    .hcount_out(m_hcount_out), .vcount_out(m_vcount_out), .frame_start_out(m_frame_start_out),
    .frame_done_out(m_frame_done_out), .frame_error_out(m_frame_error_out)
`ifdef FRAME_RECOVER_STATS_EN
    , .frame_count_out(m_frame_count_out), .last_pixel_count_out(m_last_pixel_count_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [PW-1:0] px;
    int h;
    int hm;
    int v;
    bit start;
    int cyc;
  } pix_t;

  typedef struct {
    bit err;
    int cnt;
    int fcount;
    int cyc;
  } done_t;

  pix_t pq[$];
  done_t dq[$];

  // Reference model state
  int m_state = M_SYNC;
  int m_h = 0;
  int m_v = 0;
  bit m_err = 0;
  int m_cnt = 0;
  int m_frames = 0;

  function automatic void model_edge(input logic [PW-1:0] px, input int now);
    pix_t e;
    if (m_state == M_ACTIVE) begin
      e.px = px;
      e.h = m_h;
      e.hm = H - 1 - m_h;
      e.v = m_v;
      e.start = (m_h == 0) && (m_v == 0);
      e.cyc = now + 1;
      pq.push_back(e);
      m_cnt++;
      if (m_h == H - 1) begin
        m_h = 0;
        if (m_v == V - 1) begin
          m_v = 0;
          m_state = M_OVERRUN;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end else if (m_state == M_OVERRUN) begin
      m_err = 1;
      m_cnt++;
    end
  endfunction

  function automatic void model_done(input int now);
    done_t d;
    if (m_state != M_SYNC) begin
      m_frames = (m_frames + 1) % 65536;
      d.err = (m_state == M_ACTIVE) || m_err;
      d.cnt = m_cnt;
      d.fcount = m_frames;
      d.cyc = now + 1;
      dq.push_back(d);
    end
    m_state = M_ACTIVE;
    m_h = 0;
    m_v = 0;
    m_err = 0;
    m_cnt = 0;
  endfunction

  // Monitor: compare DUT outputs against the scoreboard on the falling edge
  int n_valid = 0;
  int n_done = 0;
  int last_h = -1;
  int last_v = -1;
  always @(negedge clk) begin
    if (!rst_in) begin
      if (data_valid_out || m_data_valid_out)
        check("mirror_valid_align", m_data_valid_out, data_valid_out);
      if (data_valid_out) begin
        n_valid++;
        last_h = hcount_out;
        last_v = vcount_out;
        if (pq.size() == 0) begin
          check("spurious_valid", pq.size(), 1);
        end else begin
          pix_t e;
          e = pq.pop_front();
          check("pixel", pixel_out, e.px);
          check("hcount", hcount_out, e.h);
          check("vcount", vcount_out, e.v);
          check("frame_start", frame_start_out, e.start);
          check("valid_latency", cyc, e.cyc);
          check("mirror_pixel", m_pixel_out, e.px);
          check("mirror_hcount", m_hcount_out, e.hm);
          check("mirror_vcount", m_vcount_out, e.v);
        end
      end else if (frame_start_out) begin
        check("start_without_valid", frame_start_out, data_valid_out);
      end
      if (frame_done_out || m_frame_done_out)
        check("mirror_done_align", m_frame_done_out, frame_done_out);
      if (frame_done_out) begin
        n_done++;
        if (dq.size() == 0) begin
          check("spurious_done", dq.size(), 1);
        end else begin
          done_t d;
          d = dq.pop_front();
          check("frame_error", frame_error_out, d.err);
          check("done_latency", cyc, d.cyc);
`ifdef FRAME_RECOVER_STATS_EN
          check("last_pixel_count", last_pixel_count_out, d.cnt);
          check("frame_count", frame_count_out, d.fcount);
`endif
        end
      end else if (frame_error_out) begin
        check("error_without_done", frame_error_out, frame_done_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel: a low cycle, then high for 'hi' cycles (edge on the first)
  task automatic strobe(input int hi);
    logic [PW-1:0] px;
    px = PW'($urandom);
    tick();
    valid_pixel_in = 1'b0;
    tick();
    valid_pixel_in = 1'b1;
    pixel_in = px;
    model_edge(px, cyc);
    repeat (hi - 1) tick();
  endtask

  task automatic strobes(input int n, input int hi);
    for (int i = 0; i < n; i++) strobe(hi);
    tick();
    valid_pixel_in = 1'b0;
    tick();
  endtask

  task automatic frame_done();
    tick();
    valid_pixel_in = 1'b0;
    frame_done_in = 1'b1;
    model_done(cyc);
    tick();
    frame_done_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic done_with_edge();
    tick();
    valid_pixel_in = 1'b0;
    tick();
    valid_pixel_in = 1'b1;
    pixel_in = PW'($urandom);
    frame_done_in = 1'b1;
    model_done(cyc);
    tick();
    frame_done_in = 1'b0;
    tick();
    valid_pixel_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    tick();
    rst_in = 1'b1;
    m_state = M_SYNC;
    m_h = 0;
    m_v = 0;
    m_err = 0;
    m_cnt = 0;
    m_frames = 0;
    repeat (2) tick();
    rst_in = 1'b0;
  endtask

  int snap_v;
  int snap_d;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_data_valid", data_valid_out, 0);
    check("rst_frame_start", frame_start_out, 0);
    check("rst_frame_done", frame_done_out, 0);
    check("rst_frame_error", frame_error_out, 0);
    check("rst_state", dut.state, SYNC);
`ifdef FRAME_RECOVER_STATS_EN
    check("rst_frame_count", frame_count_out, 0);
    check("rst_last_count", last_pixel_count_out, 0);
`endif
    tick();
    rst_in = 1'b0;

    // Pixels before the first frame boundary are discarded
    strobes(3, 2);
    frame_done();
    check("sync_no_valid", n_valid, 0);
    check("sync_no_done", n_done, 0);

    // Complete frame with 2-cycle-high strobes
    snap_v = n_valid;
    strobes(H * V, 2);
    check("full_last_h", last_h, H - 1);
    check("full_last_v", last_v, V - 1);
    frame_done();
    check("full_valid_count", n_valid - snap_v, H * V);
    check("full_done_count", n_done, 1);

    // Overrun: 10 strobes into an 8-pixel frame, 3-cycle-high strobes
    snap_v = n_valid;
    strobes(10, 3);
    frame_done();
    check("overrun_valid_count", n_valid - snap_v, H * V);

    // Short frame, then empty frame
    strobes(3, 1);
    frame_done();
    frame_done();

    // frame_done_in coincident with a strobe edge drops that pixel
    strobes(2, 2);
    snap_v = n_valid;
    done_with_edge();
    check("coincident_no_valid", n_valid - snap_v, 0);
    strobes(1, 2);
    check("after_coincident_h", last_h, 0);
    check("after_coincident_v", last_v, 0);
    frame_done();

    // Reset mid-frame: no done pulse, back to SYNC
    strobes(5, 2);
    snap_d = n_done;
    do_reset();
    tick();
    check("midreset_state", dut.state, SYNC);
    strobes(2, 2);
    frame_done();
    check("midreset_no_done", n_done - snap_d, 0);
    strobes(H * V, 1);
    frame_done();
    check("post_reset_done", n_done - snap_d, 1);

    repeat (4) tick();
    check("pixel_queue_empty", pq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/frame_recover.md
FRAME_RECOVER -- requirements
Module: frame_recover

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320, pixels per line.
REQ-002 SHALL have parameter V_PIXELS, default 240, lines per frame.
REQ-003 SHALL have parameter PIXEL_W, default 16, pixel data width.
REQ-004 SHALL have parameter MIRROR_H, default 0; when 1, hcount_out reports H_PIXELS-1-column.
REQ-005 SHALL define HCOUNT_W = $clog2(H_PIXELS) and VCOUNT_W = $clog2(V_PIXELS) as localparams.
REQ-006 clk_in  input  1  sole clock, all logic on rising edge.
REQ-007 rst_in  input  1  synchronous, active-high reset.
REQ-008 valid_pixel_in  input  1  camera pixel strobe, may stay high for several cycles per pixel.
REQ-009 pixel_in  input  PIXEL_W  raw pixel data, sampled on the strobe's rising edge.
REQ-010 frame_done_in  input  1  end-of-frame indication from the camera.
REQ-011 pixel_out  output  PIXEL_W  registered pixel data.
REQ-012 data_valid_out  output  1  one-cycle qualifier for pixel_out and the counts.
REQ-013 hcount_out  output  HCOUNT_W  column of pixel_out.
REQ-014 vcount_out  output  VCOUNT_W  line of pixel_out.
REQ-015 frame_start_out  output  1  one-cycle pulse coincident with the first pixel of a frame.
REQ-016 frame_done_out  output  1  one-cycle pulse one cycle after frame_done_in is accepted.
REQ-017 frame_error_out  output  1  valid with frame_done_out; high when the pixel count differed from H_PIXELS*V_PIXELS.

Function
REQ-018 SHALL accept one pixel per rising edge of valid_pixel_in (low then high on consecutive cycles); level-high cycles after the edge SHALL be ignored.
REQ-019 SHALL present each accepted pixel on pixel_out with data_valid_out high exactly one cycle after the edge cycle; data_valid_out SHALL be low otherwise.
REQ-020 SHALL use FSM states SYNC, ACTIVE and OVERRUN.
REQ-021 SYNC: discard all pixels; on frame_done_in, go to ACTIVE with no frame_done_out pulse.
REQ-022 ACTIVE: emit pixels in raster order; column wraps from H_PIXELS-1 to 0 with line+1.
REQ-023 ACTIVE: after pixel (H_PIXELS-1, V_PIXELS-1), go to OVERRUN.
REQ-024 OVERRUN: drop further pixels (no data_valid_out) and set the internal error flag.
REQ-025 ACTIVE or OVERRUN: on frame_done_in, clear the counts and go to ACTIVE; pulse frame_done_out next cycle.
REQ-026 frame_error_out SHALL be high with frame_done_out if the frame was short, including an empty frame, or overran.
REQ-027 frame_start_out SHALL be high with data_valid_out for pixel (0,0) only.
REQ-028 When frame_done_in and a strobe edge occur in the same cycle, frame_done_in SHALL win and the pixel SHALL be dropped.

Reset
REQ-029 On rst_in, SHALL enter SYNC and clear the counts, error flag, edge-detect register and all 1-bit outputs.
REQ-030 pixel_out SHALL reset to 0.
REQ-031 A reset asserted mid-frame SHALL abandon the frame with no frame_done_out.

Configuration
REQ-032 With FRAME_RECOVER_STATS_EN defined, SHALL add output frame_count_out [15:0], incremented (wrapping) per frame_done_out, and output last_pixel_count_out [19:0], updated at frame_done_out with the pixels received in the frame, counting dropped overrun pixels, saturating at 2^20-1; both reset to 0.
REQ-033 Without FRAME_RECOVER_STATS_EN, those ports and the statistics logic SHALL NOT exist.

Structure
REQ-034 Default camera geometry constants CAM_H_PIXELS=320, CAM_V_PIXELS=240, CAM_PIXEL_W=16 and the FSM state enum SHALL live in laser_chaser_pkg.
REQ-035 The strobe edge detector SHALL be a sub-module rising_edge_detect (input level, output one-cycle pulse).

Verification
REQ-036 Reset, frame_done_in, then 320*240 strobes each 2 cycles high -> 76800 valid pixels, last at (319,239); frame_done_out=1 with frame_error_out=0.
REQ-037 Pixels before the first frame_done_in after reset -> no data_valid_out, no frame_done_out.
REQ-038 H_PIXELS=4, V_PIXELS=2, 10 strobes -> 8 valid pixels, 2 dropped, frame_error_out=1; stats build: last_pixel_count_out=10.
REQ-039 MIRROR_H=1, H_PIXELS=4: first line reports hcount_out 3,2,1,0 with vcount_out 0.
REQ-040 frame_done_in coincident with a strobe edge -> no data_valid_out; next accepted pixel is (0,0) with frame_start_out=1.
REQ-041 rst_in after 100 pixels -> no frame_done_out; state returns to SYNC.
